cache_ctrl_fsm: RTL and testbench
=================================

# cache_ctrl_fsm

Parametrised cache controller sequencer. It replaces the fixed direct-mapped write-through controller and adds multi-word line refill, selectable write-back or write-through policy with dirty-line eviction, and saturating hit/miss statistics counters. It sits between the CPU request port, the tag/data arrays and the RAM interface. It only drives control strobes; the address and data paths are external.

## Interface
Parameters:
- WORDS_PER_LINE, default 4: words per cache line; must be a power of two and ≥ 2.
- WRITE_BACK, default 1: 1 selects write-back with dirty eviction; 0 selects write-through.
- CNT_W, default 16: width of the statistics counters.

Ports (IW = $clog2(WORDS_PER_LINE)):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; captured with cpu_req.
- hit  in  1  tag-compare result; valid in LOOKUP.
- dirty  in  1  dirty bit of the indexed line; valid in LOOKUP.
- mem_ack  in  1  RAM finished the current word; ignored while mem_req = 0.
- cnt_clr  in  1  synchronous clear of both statistics counters.
- tag_rd_en  out  1  read the tag array.
- data_rd_en  out  1  read the data array.
- cache_we  out  1  write one data-array word.
- sel_cpu  out  1  data-array write source: 1 = CPU, 0 = RAM.
- tag_we  out  1  write tag and set valid.
- dirty_set  out  1  set the dirty bit.
- dirty_clr  out  1  clear the dirty bit.
- mem_req  out  1  RAM transfer request.
- mem_we  out  1  1 = RAM write, 0 = RAM read.
- word_idx  out  IW  word index for eviction and refill.
- cpu_done  out  1  one-cycle completion pulse.
- hit_cnt  out  CNT_W  hits counted.
- miss_cnt  out  CNT_W  misses counted.

## Operation
- Captured request type: cpu_we is registered in IDLE when cpu_req = 1. Changes to cpu_req or cpu_we after that are ignored until cpu_done.
- IDLE: all strobes 0. cpu_req = 1 → LOOKUP.
- LOOKUP: tag_rd_en = 1; data_rd_en = ~captured_we. Next state:
  - hit and read → HIT_RD.
  - hit and write → HIT_WR.
  - miss, WRITE_BACK = 1 and dirty → EVICT.
  - any other miss → REFILL.
- HIT_RD: cpu_done = 1, then → IDLE.
- HIT_WR: cache_we = 1, sel_cpu = 1.
  - WRITE_BACK = 1: also dirty_set = 1 and cpu_done = 1, then → IDLE.
  - WRITE_BACK = 0: → WT_MEM.
- WT_MEM: mem_req = 1, mem_we = 1. On mem_ack: cpu_done = 1 and → IDLE.
- EVICT: mem_req = 1, mem_we = 1, data_rd_en = 1.
  - Each mem_ack advances word_idx.
  - mem_ack with word_idx = WORDS_PER_LINE-1 → REFILL, with word_idx wrapped to 0.
- REFILL: mem_req = 1, mem_we = 0, sel_cpu = 0.
  - cache_we = mem_ack in the same cycle. This Mealy output is the only one in the block.
  - Each mem_ack advances word_idx. The last word wraps word_idx to 0 → UPDATE.
- UPDATE: tag_we = 1, dirty_clr = 1, then → LOOKUP (re-lookup; it hits and completes the request through the hit path).
- Statistics counters:
  - An internal retry flag is set in UPDATE and cleared on cpu_done. Only the first LOOKUP of a request, i.e. with retry = 0, updates the counters.
  - That LOOKUP increments hit_cnt if hit = 1, otherwise miss_cnt.
  - Both counters saturate at all-ones.
  - cnt_clr zeroes both counters. If cnt_clr and an increment occur in the same cycle, the clear wins.
- word_idx is 0 in every state other than EVICT and REFILL.
- Reset (reset = 0, at any time including mid-burst):
  - State → IDLE immediately; retry → 0.
  - Every output is 0, including word_idx, hit_cnt and miss_cnt.
  - An interrupted transaction is abandoned and produces no cpu_done.

## Timing
Edge k is the edge that samples cpu_req = 1 in IDLE.
- Read hit: LOOKUP in cycle k+1; cpu_done in cycle k+2.
- Write hit, write-back: cache_we and cpu_done in cycle k+2.
- Write hit, write-through: cpu_done in the cycle mem_ack is seen in WT_MEM. With mem_ack held high this is cycle k+3.
- Clean miss, WORDS_PER_LINE = 4, mem_ack held high:
  - REFILL in cycles k+2..k+5.
  - UPDATE in cycle k+6.
  - LOOKUP in cycle k+7.
  - cpu_done in cycle k+8.
- A dirty miss adds WORDS_PER_LINE cycles of EVICT before REFILL.
- mem_ack stalls of any length keep the current state and word_idx unchanged.
- cpu_done is never high for two consecutive cycles. A new request can be sampled on the edge after cpu_done.

## Test plan
- Reset: drive reset = 0 mid-REFILL at word_idx = 2 → all outputs 0 and state IDLE in the same cycle. Release reset, issue a read hit → cpu_done at k+2, hit_cnt = 1.
- Read miss, WRITE_BACK = 1, clean line, mem_ack = 1 every cycle → cache_we pulses with word_idx = 0,1,2,3, then one tag_we, then cpu_done at k+8. miss_cnt = 1, hit_cnt = 0 (the retry lookup is not counted).
- Write miss on a dirty line → 4 EVICT acks with mem_we = 1 and word_idx 0..3, then 4 REFILL acks, UPDATE, HIT_WR with dirty_set = 1 and cpu_done. mem_ack is toggled 1-0-1 during EVICT and word_idx holds during the 0 cycle.
- WRITE_BACK = 0, write hit, mem_ack delayed 3 cycles → cache_we = 1 at k+2, mem_req = 1 for 3 cycles, cpu_done when mem_ack arrives, dirty_set never asserted.
- Counters: preload by issuing 2^CNT_W + 3 read hits → hit_cnt saturates at all-ones. Assert cnt_clr in the same cycle as a counted LOOKUP → hit_cnt = 0.
- Toggle cpu_req and cpu_we during a miss → transaction follows the captured type, exactly one cpu_done.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
// Cache controller sequencer: lookup, hit/write paths, dirty eviction, multi-word refill, hit/miss stats.
// Latency: read hit completes two cycles after the request is sampled; misses add eviction and refill bursts.
// Backpressure: the RAM side is paced by mem_ack; without an ack the state and word_idx hold.
module cache_ctrl_fsm #(
  parameter int WORDS_PER_LINE = 4,
  parameter int WRITE_BACK     = 1,
  parameter int CNT_W          = 16,
  localparam int IW            = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic             hit,
  input  logic             dirty,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             tag_rd_en,
  output logic             data_rd_en,
  output logic             cache_we,
  output logic             sel_cpu,
  output logic             tag_we,
  output logic             dirty_set,
  output logic             dirty_clr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [IW-1:0]    word_idx,
  output logic             cpu_done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_HIT_RD, S_HIT_WR, S_WT_MEM, S_EVICT, S_REFILL, S_UPDATE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_LINE - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] idx_nxt;
  logic          we_q;
  logic          retry;
  logic          last_word;

  assign last_word = (word_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      word_idx <= '0;
      we_q     <= 1'b0;
      retry    <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_idx <= idx_nxt;
      if (state == S_IDLE && cpu_req)
        we_q <= cpu_we;
      if (cpu_done)
        retry <= 1'b0;
      else if (state == S_UPDATE)
        retry <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = word_idx;
    tag_rd_en  = 1'b0;
    data_rd_en = 1'b0;
    cache_we   = 1'b0;
    sel_cpu    = 1'b0;
    tag_we     = 1'b0;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    cpu_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_req)
          state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        tag_rd_en  = 1'b1;
        data_rd_en = ~we_q;
        if (hit)
          state_nxt = we_q ? S_HIT_WR : S_HIT_RD;
        else if (WRITE_BACK != 0 && dirty)
          state_nxt = S_EVICT;
        else
          state_nxt = S_REFILL;
      end
      S_HIT_RD: begin
        cpu_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_HIT_WR: begin
        cache_we = 1'b1;
        sel_cpu  = 1'b1;
        if (WRITE_BACK != 0) begin
          dirty_set = 1'b1;
          cpu_done  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WT_MEM;
        end
      end
      S_WT_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          cpu_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_EVICT: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        data_rd_en = 1'b1;
        if (mem_ack) begin
          // Power-of-two line length: the increment wraps to 0 on the last word.
          idx_nxt = word_idx + IW'(1);
          if (last_word)
            state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        cache_we = mem_ack;
        if (mem_ack) begin
          idx_nxt = word_idx + IW'(1);
          if (last_word)
            state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        tag_we    = 1'b1;
        dirty_clr = 1'b1;
        state_nxt = S_LOOKUP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Only the first lookup of a request is counted; the post-refill lookup is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP && !retry) begin
      if (hit) begin
        if (hit_cnt != '1)
          hit_cnt <= hit_cnt + CNT_W'(1);
      end else if (miss_cnt != '1) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: one write-back and one write-through instance, a directed
// vector table, hand-written corner sequences and random transactions against a transaction-level model.
module tb_cache_ctrl_fsm;
  localparam int WPL  = 4;
  localparam int IW   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk, rst_n;
  logic cpu_req, cpu_we, hit, dirty, mem_ack, cnt_clr;
  logic sel;
  logic [1:0] req_v;
  logic [1:0] tag_rd_v, data_rd_v, cache_we_v, sel_cpu_v, tag_we_v, dset_v, dclr_v, mreq_v, mwe_v, done_v;
  logic [IW-1:0] widx_v [2];
  logic [CW-1:0] hcnt_v [2];
  logic [CW-1:0] mcnt_v [2];

  assign req_v[0] = cpu_req & ~sel;
  assign req_v[1] = cpu_req & sel;

  cache_ctrl_fsm #(.WORDS_PER_LINE(WPL), .WRITE_BACK(1), .CNT_W(CW)) dut_wb (
    .clk(clk), .reset(rst_n), .cpu_req(req_v[0]), .cpu_we(cpu_we), .hit(hit), .dirty(dirty),
    .mem_ack(mem_ack), .cnt_clr(cnt_clr), .tag_rd_en(tag_rd_v[0]), .data_rd_en(data_rd_v[0]),
    .cache_we(cache_we_v[0]), .sel_cpu(sel_cpu_v[0]), .tag_we(tag_we_v[0]), .dirty_set(dset_v[0]),
    .dirty_clr(dclr_v[0]), .mem_req(mreq_v[0]), .mem_we(mwe_v[0]), .word_idx(widx_v[0]),
    .cpu_done(done_v[0]), .hit_cnt(hcnt_v[0]), .miss_cnt(mcnt_v[0]));

  cache_ctrl_fsm #(.WORDS_PER_LINE(WPL), .WRITE_BACK(0), .CNT_W(CW)) dut_wt (
    .clk(clk), .reset(rst_n), .cpu_req(req_v[1]), .cpu_we(cpu_we), .hit(hit), .dirty(dirty),
    .mem_ack(mem_ack), .cnt_clr(cnt_clr), .tag_rd_en(tag_rd_v[1]), .data_rd_en(data_rd_v[1]),
    .cache_we(cache_we_v[1]), .sel_cpu(sel_cpu_v[1]), .tag_we(tag_we_v[1]), .dirty_set(dset_v[1]),
    .dirty_clr(dclr_v[1]), .mem_req(mreq_v[1]), .mem_we(mwe_v[1]), .word_idx(widx_v[1]),
    .cpu_done(done_v[1]), .hit_cnt(hcnt_v[1]), .miss_cnt(mcnt_v[1]));

  logic o_tag_rd, o_data_rd, o_cache_we, o_sel_cpu, o_tag_we, o_dset, o_dclr, o_mreq, o_mwe, o_done;
  logic [IW-1:0] o_widx;
  logic [CW-1:0] o_hcnt, o_mcnt;
  logic [19:0]   o_all;
  assign o_tag_rd   = tag_rd_v[sel];
  assign o_data_rd  = data_rd_v[sel];
  assign o_cache_we = cache_we_v[sel];
  assign o_sel_cpu  = sel_cpu_v[sel];
  assign o_tag_we   = tag_we_v[sel];
  assign o_dset     = dset_v[sel];
  assign o_dclr     = dclr_v[sel];
  assign o_mreq     = mreq_v[sel];
  assign o_mwe      = mwe_v[sel];
  assign o_done     = done_v[sel];
  assign o_widx     = widx_v[sel];
  assign o_hcnt     = hcnt_v[sel];
  assign o_mcnt     = mcnt_v[sel];
  assign o_all = {o_tag_rd, o_data_rd, o_cache_we, o_sel_cpu, o_tag_we, o_dset, o_dclr,
                  o_mreq, o_mwe, o_done, o_widx, o_hcnt, o_mcnt};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int m_hit [2];
  int m_miss[2];
  int ob_done, ob_done_cyc, ob_evict, ob_refill, ob_tag, ob_dset, ob_cpuwr, ob_memreq, ob_err;

  typedef struct {
    logic sel;
    logic we;
    logic h;
    logic d;
    int   done_cyc;
    int   evict;
    int   refill;
    int   dset;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Statistics model: first lookup counts, saturating; a clear drives both instances to zero.
  task automatic model_count(input logic h, input bit clr);
    if (clr) begin
      m_hit  = '{0, 0};
      m_miss = '{0, 0};
    end else if (h) begin
      if (m_hit[sel] < MAXC) m_hit[sel]++;
    end else begin
      if (m_miss[sel] < MAXC) m_miss[sel]++;
    end
  endtask

  task automatic run_txn(input logic sel_i, input logic we, input logic h, input logic d,
                         input int ack_pct, input logic [31:0] ack_pat, input bit use_pat,
                         input bit garbage, input bit clr, input int abort_idx);
    int lookups, mcyc;
    bit fin;
    @(negedge clk);
    sel = sel_i;
    cpu_req = 1'b1;
    cpu_we = we;
    {ob_done, ob_done_cyc, ob_evict, ob_refill, ob_tag, ob_dset, ob_cpuwr, ob_memreq, ob_err} = '0;
    lookups = 0;
    mcyc = 0;
    fin = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 300 && !fin; n++) begin
      @(negedge clk);
      cpu_req = garbage ? 1'($urandom) : 1'b0;
      cpu_we  = garbage ? 1'($urandom) : we;
      hit     = 1'($urandom);
      dirty   = 1'($urandom);
      cnt_clr = 1'b0;
      if (o_tag_rd) begin
        hit   = (lookups == 0) ? h : 1'b1;
        dirty = d;
        if (lookups == 0) begin
          cnt_clr = clr;
          model_count(h, clr);
        end
        lookups++;
      end
      if (o_mreq) begin
        mem_ack = use_pat ? ((mcyc < 32) ? ack_pat[mcyc] : 1'b1) : ($urandom_range(99) < ack_pct);
        mcyc++;
      end else begin
        mem_ack = 1'($urandom);
      end
      #1;
      if (o_tag_rd && (o_data_rd !== ~we)) ob_err++;
      if (o_mreq && o_mwe && o_data_rd) begin
        if (o_widx != IW'(ob_evict % WPL)) ob_err++;
        if (mem_ack) ob_evict++;
      end else if (o_mreq && !o_mwe) begin
        if (o_widx != IW'(ob_refill % WPL)) ob_err++;
        if (o_cache_we !== mem_ack || o_sel_cpu) ob_err++;
        if (abort_idx >= 0 && mem_ack && o_widx == IW'(abort_idx)) begin
          rst_n = 1'b0;
          cpu_req = 1'b0;
          #1;
          check("reset_mid_refill_outputs", int'(o_all), 0);
          m_hit  = '{0, 0};
          m_miss = '{0, 0};
          fin = 1'b1;
        end
        if (mem_ack) ob_refill++;
      end else if (o_widx != '0) begin
        ob_err++;
      end
      if (o_mreq) ob_memreq++;
      if (o_cache_we && o_sel_cpu) ob_cpuwr++;
      if (o_tag_we) ob_tag++;
      if (o_dclr !== o_tag_we) ob_err++;
      if (o_dset) ob_dset++;
      if (o_done) begin
        ob_done++;
        ob_done_cyc = n;
        fin = 1'b1;
        cpu_req = 1'b0;
      end
    end
    cnt_clr = 1'b0;
  endtask

  task automatic check_std(input string tg, input int dcyc, input int ev, input int rf,
                           input int ds, input int cw);
    check({tg, ".done"}, ob_done, 1);
    if (dcyc > 0) check({tg, ".done_cycle"}, ob_done_cyc, dcyc);
    check({tg, ".evict_acks"}, ob_evict, ev);
    check({tg, ".refill_acks"}, ob_refill, rf);
    check({tg, ".tag_we"}, ob_tag, (rf > 0) ? 1 : 0);
    check({tg, ".dirty_set"}, ob_dset, ds);
    check({tg, ".cpu_writes"}, ob_cpuwr, cw);
    check({tg, ".protocol_errs"}, ob_err, 0);
    check({tg, ".hit_cnt"}, int'(o_hcnt), m_hit[sel]);
    check({tg, ".miss_cnt"}, int'(o_mcnt), m_miss[sel]);
  endtask

  initial begin
    logic rwe, rh, rd;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0,  2, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1,  2, 0, 0, 1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0,  8, 0, 4, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 12, 4, 4, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0,  8, 0, 4, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 12, 4, 4, 1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0,  2, 0, 0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0,  3, 0, 0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1,  8, 0, 4, 0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1,  9, 0, 4, 0};
    m_hit  = '{0, 0};
    m_miss = '{0, 0};
    sel = 1'b0;
    {cpu_req, cpu_we, hit, dirty, mem_ack, cnt_clr} = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_wb", int'(o_all), 0);
    sel = 1'b1;
    #1;
    check("reset_outputs_wt", int'(o_all), 0);
    sel = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].sel, tbl[i].we, tbl[i].h, tbl[i].d, 100, 32'h0, 1'b0, 1'b0, 1'b0, -1);
      check_std($sformatf("tbl%0d", i), tbl[i].done_cyc, tbl[i].evict, tbl[i].refill,
                tbl[i].dset, int'(tbl[i].we));
    end

    // Reset in the middle of a refill burst, then a clean read hit.
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 100, 32'h0, 1'b0, 1'b0, 1'b0, 2);
    check("abort.no_done", ob_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 100, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    check_std("post_reset_hit", 2, 0, 0, 0, 0);
    check("post_reset_hit_cnt", int'(o_hcnt), 1);

    // Dirty write miss with an ack gap on the second eviction word and toggling CPU inputs.
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 100, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, -1);
    check_std("dirty_wr_miss_stall", 13, 4, 4, 1, 1);

    // Write-through write hit, RAM acks on the third request cycle.
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h4, 1'b1, 1'b0, 1'b0, -1);
    check_std("wt_wr_hit_delayed", 5, 0, 0, 0, 1);
    check("wt_wr_hit_memreq_cycles", ob_memreq, 3);

    for (int i = 0; i < (1 << CW) + 3; i++)
      run_txn(1'b0, 1'b0, 1'b1, 1'b0, 100, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    check("hit_cnt_saturated", int'(o_hcnt), MAXC);
    check("hit_cnt_sat_model", int'(o_hcnt), m_hit[0]);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 100, 32'h0, 1'b0, 1'b0, 1'b1, -1);
    check("clr_beats_inc_hit", int'(o_hcnt), 0);
    check("clr_beats_inc_miss", int'(o_mcnt), 0);

    for (int i = 0; i < 40; i++) begin
      rwe = 1'($urandom);
      rh  = 1'($urandom);
      rd  = 1'($urandom);
      run_txn(1'b0, rwe, rh, rd, 60, 32'h0, 1'b0, 1'b1, 1'b0, -1);
      check_std($sformatf("rand%0d", i), 0, (!rh && rd) ? WPL : 0, !rh ? WPL : 0,
                int'(rwe), int'(rwe));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
